// File: rtl/wdt_pkg.sv
// Shared register map and bit positions for the parametrised watchdog.
// Purely declarative; imported by the watchdog top and its sub-modules.
package wdt_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;
  localparam logic [2:0] ADDR_PRETHR  = 3'd6;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;
  localparam int STAT_PTO = 2;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_PIE   = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Field order matches the STATUS read layout (TO in bit 0).
  typedef struct packed {
    logic pto;
    logic run;
    logic to;
  } status_t;

endpackage

// File: rtl/wdt_reset_stretcher.sv
// Stretches a one-cycle trigger into a RST_PULSE-cycle pulse; a retrigger reloads.
// Latency: pulse rises the cycle after trigger; no backpressure.
module wdt_reset_stretcher #(
  parameter int RST_PULSE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  output logic pulse
);

  localparam int CW = $clog2(RST_PULSE + 1);
  localparam logic [CW-1:0] LOAD = CW'(RST_PULSE);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (trigger) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign pulse = (r_cnt != '0);

endmodule

// File: rtl/wdt_timer_param.sv
// Avalon-MM watchdog: reloadable down-counter, pre-timeout IRQ, snapshot, stretched reset request.
// Latency: reads registered with 1 cycle, no wait states; writes always accepted (no backpressure).
module wdt_timer_param
  import wdt_pkg::*;
#(
  parameter int          COUNT_W        = 29,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h1DCD64FF,
  parameter bit          ALLOW_STOP     = 1'b0,
  parameter int          RST_PULSE      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        resetrequest
);

  localparam logic [COUNT_W-1:0] P_DEF = DEFAULT_PERIOD[COUNT_W-1:0];

  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] r_snap;
  logic [15:0]        r_prethr;
  status_t            r_status;
  logic               r_ito;
  logic               r_pie;
  logic               r_force_reload;
  logic               r_zero_d1;
  logic               r_pre_d1;

  logic               w_wr;
  logic               w_wr_status;
  logic               w_wr_control;
  logic               w_wr_periodl;
  logic               w_wr_periodh;
  logic               w_wr_snapl;
  logic               w_wr_prethr;
  logic               w_zero;
  logic               w_pre_cmp;
  logic               w_timeout_event;
  logic               w_pre_event;
  logic [31:0]        w_period_ext;
  logic [31:0]        w_snap_ext;
  logic [15:0]        w_rd_mux;

  assign w_wr         = chipselect & ~write_n;
  assign w_wr_status  = w_wr && (address == ADDR_STATUS);
  assign w_wr_control = w_wr && (address == ADDR_CONTROL);
  assign w_wr_periodl = w_wr && (address == ADDR_PERIODL);
  assign w_wr_periodh = w_wr && (address == ADDR_PERIODH);
  assign w_wr_snapl   = w_wr && (address == ADDR_SNAPL);
  assign w_wr_prethr  = w_wr && (address == ADDR_PRETHR);

  // Events are edge-qualified so a counter parked at 0 or at the threshold fires once.
  assign w_zero          = (r_count == '0);
  assign w_timeout_event = w_zero & ~r_zero_d1;
  assign w_pre_cmp       = r_status.run && (r_prethr != 16'd0) &&
                           (r_count == {{(COUNT_W-16){1'b0}}, r_prethr});
  assign w_pre_event     = w_pre_cmp & ~r_pre_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period       <= P_DEF;
      r_force_reload <= 1'b0;
      r_prethr       <= 16'd0;
    end else begin
      r_force_reload <= w_wr_periodl | w_wr_periodh;
      if (w_wr_periodl) r_period[15:0] <= writedata;
      if (w_wr_periodh) r_period[COUNT_W-1:16] <= writedata[COUNT_W-17:0];
      if (w_wr_prethr)  r_prethr <= writedata;
    end
  end

  // Kick reloads from the already-updated PERIOD, independent of RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= P_DEF;
    end else if (r_force_reload) begin
      r_count <= r_period;
    end else if (r_status.run) begin
      if (w_zero) r_count <= r_period;
      else        r_count <= r_count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_d1 <= 1'b0;
      r_pre_d1  <= 1'b0;
      r_snap    <= '0;
    end else begin
      r_zero_d1 <= w_zero;
      r_pre_d1  <= w_pre_cmp;
      if (w_wr_snapl) r_snap <= r_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status <= '0;
      r_ito    <= 1'b0;
      r_pie    <= 1'b0;
    end else begin
      if (w_timeout_event)  r_status.to <= 1'b1;
      else if (w_wr_status) r_status.to <= 1'b0;

      if (w_pre_event)      r_status.pto <= 1'b1;
      else if (w_wr_status) r_status.pto <= 1'b0;

      if (w_wr_control) begin
        r_ito <= writedata[CTRL_ITO];
        r_pie <= writedata[CTRL_PIE];
        if (writedata[CTRL_START])
          r_status.run <= 1'b1;
        else if (writedata[CTRL_STOP] && ALLOW_STOP)
          r_status.run <= 1'b0;
      end
    end
  end

  assign w_period_ext = 32'(r_period);
  assign w_snap_ext   = 32'(r_snap);

  always_comb begin
    w_rd_mux = 16'd0;
    case (address)
      ADDR_STATUS:  w_rd_mux = {13'd0, r_status};
      ADDR_CONTROL: w_rd_mux = {14'd0, r_pie, r_ito};
      ADDR_PERIODL: w_rd_mux = w_period_ext[15:0];
      ADDR_PERIODH: w_rd_mux = w_period_ext[31:16];
      ADDR_SNAPL:   w_rd_mux = w_snap_ext[15:0];
      ADDR_SNAPH:   w_rd_mux = w_snap_ext[31:16];
      ADDR_PRETHR:  w_rd_mux = r_prethr;
      default:      w_rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 16'd0;
    else          readdata <= w_rd_mux;
  end

  assign irq = (r_status.to & r_ito) | (r_status.pto & r_pie);

  wdt_reset_stretcher #(
    .RST_PULSE (RST_PULSE)
  ) u_stretch (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (w_timeout_event),
    .pulse   (resetrequest)
  );

endmodule

// File: tb/tb_wdt_timer_param.sv
// Directed bench for wdt_timer_param: instance A locks RUN (24-bit), instance B allows STOP (20-bit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wdt_timer_param;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic        cs_a, cs_b;
  logic [15:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic        rr_a, rr_b;
  logic [15:0] rdv;

  int n_assert = 0;
  int n_fail   = 0;

  wdt_timer_param #(
    .COUNT_W(24), .DEFAULT_PERIOD(32'd100), .ALLOW_STOP(1'b0), .RST_PULSE(3)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .irq(irq_a), .resetrequest(rr_a)
  );

  wdt_timer_param #(
    .COUNT_W(20), .DEFAULT_PERIOD(32'd100), .ALLOW_STOP(1'b1), .RST_PULSE(3)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .irq(irq_b), .resetrequest(rr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the next rising edge samples the write.
  task automatic bus_write(input bit sel_b, input logic [2:0] a, input logic [15:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = ~sel_b;
    cs_b      = sel_b;
    @(negedge clk);
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  task automatic bus_read(input bit sel_b, input logic [2:0] a, output logic [15:0] d);
    address = a;
    cs_a    = ~sel_b;
    cs_b    = sel_b;
    @(negedge clk);
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    d       = sel_b ? rd_b : rd_a;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = 3'd0;
    write_n   = 1'b1;
    writedata = 16'd0;
    cs_a      = 1'b0;
    cs_b      = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_readdata", rd_a, 0);
    chk("rst_irq", irq_a, 0);
    chk("rst_resetrequest", rr_a, 0);
    reset_n = 1'b1;
    bus_read(0, 3'd0, rdv); chk("rst_status", rdv, 16'h0000);
    bus_read(0, 3'd2, rdv); chk("rst_periodl", rdv, 16'd100);
    bus_read(0, 3'd3, rdv); chk("rst_periodh", rdv, 16'h0000);
    bus_read(0, 3'd1, rdv); chk("rst_control", rdv, 16'h0000);
    bus_read(0, 3'd6, rdv); chk("rst_prethr", rdv, 16'h0000);
    bus_read(0, 3'd4, rdv); chk("rst_snapl", rdv, 16'h0000);
    bus_read(0, 3'd7, rdv); chk("addr7_read", rdv, 16'h0000);
    bus_read(1, 3'd2, rdv); chk("rst_periodl_b", rdv, 16'd100);

    // 1: timeout 101 cycles after START, 3-cycle reset request
    do_reset();
    bus_write(0, 3'd1, 16'h0005);
    repeat (100) @(negedge clk);
    chk("t1_irq_before", irq_a, 0);
    chk("t1_rr_before", rr_a, 0);
    @(negedge clk);
    chk("t1_irq_at101", irq_a, 1);
    chk("t1_rr_c1", rr_a, 1);
    @(negedge clk);
    chk("t1_rr_c2", rr_a, 1);
    @(negedge clk);
    chk("t1_rr_c3", rr_a, 1);
    @(negedge clk);
    chk("t1_rr_end", rr_a, 0);
    bus_read(0, 3'd0, rdv); chk("t1_status", rdv, 16'h0003);

    // 2: kick at counter 10 reloads 50
    do_reset();
    bus_write(0, 3'd1, 16'h0005);
    repeat (90) @(negedge clk);
    bus_write(0, 3'd2, 16'd50);
    @(negedge clk);
    bus_write(0, 3'd4, 16'h0000);
    bus_read(0, 3'd4, rdv); chk("t2_snap_after_kick", rdv, 16'd50);
    repeat (48) @(negedge clk);
    chk("t2_no_early_to", irq_a, 0);
    @(negedge clk);
    chk("t2_to_after_50", irq_a, 1);

    // 3: pre-timeout at counter 20
    do_reset();
    bus_write(0, 3'd6, 16'd20);
    bus_write(0, 3'd1, 16'h0006);
    repeat (80) @(negedge clk);
    chk("t3_irq_before_pto", irq_a, 0);
    @(negedge clk);
    chk("t3_irq_pto", irq_a, 1);
    bus_read(0, 3'd0, rdv); chk("t3_status_pto", rdv, 16'h0006);
    bus_write(0, 3'd0, 16'h0000);
    chk("t3_irq_cleared", irq_a, 0);
    bus_read(0, 3'd0, rdv); chk("t3_status_cleared", rdv, 16'h0002);

    // 4: stop lock vs stop allowed
    do_reset();
    bus_write(0, 3'd1, 16'h0004);
    bus_write(0, 3'd1, 16'h0008);
    bus_read(0, 3'd0, rdv); chk("t4_a_run_locked", rdv, 16'h0002);
    bus_write(1, 3'd1, 16'h0004);
    repeat (9) @(negedge clk);
    bus_write(1, 3'd1, 16'h0008);
    bus_write(1, 3'd4, 16'h0000);
    bus_read(1, 3'd4, rdv); chk("t4_b_snap_stop", rdv, 16'd90);
    repeat (10) @(negedge clk);
    bus_write(1, 3'd4, 16'h0000);
    bus_read(1, 3'd4, rdv); chk("t4_b_snap_held", rdv, 16'd90);
    bus_read(1, 3'd0, rdv); chk("t4_b_run_off", rdv, 16'h0000);
    chk("t4_b_irq", irq_b, 0);

    // 5: 20-bit period / snapshot width
    do_reset();
    bus_write(1, 3'd3, 16'hFFFF);
    bus_write(1, 3'd2, 16'h0000);
    bus_read(1, 3'd3, rdv); chk("t5_periodh", rdv, 16'h000F);
    bus_write(1, 3'd4, 16'h0000);
    bus_read(1, 3'd4, rdv); chk("t5_snapl", rdv, 16'h0000);
    bus_read(1, 3'd5, rdv); chk("t5_snaph", rdv, 16'h000F);
    bus_read(1, 3'd2, rdv); chk("t5_periodl", rdv, 16'h0000);
    chk("t5_b_rr", rr_b, 0);

    // 6: STATUS write colliding with timeout, then reset mid-pulse
    do_reset();
    bus_write(0, 3'd1, 16'h0005);
    repeat (100) @(negedge clk);
    bus_write(0, 3'd0, 16'h0000);
    chk("t6_irq_set_wins", irq_a, 1);
    chk("t6_rr_on", rr_a, 1);
    bus_read(0, 3'd0, rdv); chk("t6_status", rdv, 16'h0003);
    chk("t6_rr_still_on", rr_a, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rr_async_rst", rr_a, 0);
    chk("t6_rd_async_rst", rd_a, 0);
    chk("t6_irq_async_rst", irq_a, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_timer_param.md
Name: wdt_timer_param

Overview:
- Parametrised successor to the fixed-period system watchdog; Avalon-MM slave, 16-bit data bus, 3-bit word address.
- Down-counter with a software-writable period, a kick (service) mechanism, an optional pre-timeout warning interrupt, counter snapshot readback, an optional stop lock, and a stretched reset-request pulse.
- Sits beside the CPU as an IRQ source; drives the system reset controller.

Parameters:
COUNT_W, 29, counter width in bits; legal range 17..32.
DEFAULT_PERIOD, 29'h1DCD64FF, reset value of PERIOD and counter; only bits [COUNT_W-1:0] are used.
ALLOW_STOP, 0, 1 = CONTROL.STOP is honoured; 0 = STOP is ignored and the watchdog cannot be stopped once started.
RST_PULSE, 2, number of cycles resetrequest is held high per timeout; must be >= 1.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  level interrupt
resetrequest  out  1  system reset request

Behaviour:
Reset values:
- counter = PERIOD = DEFAULT_PERIOD; PRETHR = 0.
- RUN, TO, PTO, ITO, PIE = 0; readdata = 0; irq = 0; resetrequest = 0; snapshot = 0.

Register map (wr = chipselect & ~write_n):
- 0 STATUS: bit0 TO, bit1 RUN, bit2 PTO. Any write clears TO and PTO.
- 1 CONTROL: bit0 ITO, bit1 PIE are read/write. bit2 START is a write-1 strobe. bit3 STOP is a write-1 strobe. START and STOP read as 0.
- 2 PERIODL: bits [15:0]. A write also kicks.
- 3 PERIODH: bits [COUNT_W-1:16]. Unused bits are ignored on write and read back as 0. A write also kicks.
- 4 SNAPL: any write captures counter into snapshot. Reads return snapshot[15:0].
- 5 SNAPH: reads return snapshot[COUNT_W-1:16], zero-extended.
- 6 PRETHR: 16-bit pre-timeout threshold. 0 disables the pre-timeout.
- 7: reads 0; writes ignored.

Read path:
- readdata is registered every cycle from the address-decoded mux.
- Value is valid the cycle after the address is presented (1-cycle latency, no wait states).

Kick:
- force_reload is registered high the cycle after a PERIODL or PERIODH write.
- While force_reload is high, the counter loads PERIOD, which already holds the newly written half. This happens regardless of RUN.

Counter:
- When RUN is set and there is no force_reload, the counter decrements by 1 per clk.
- At 0 it reloads PERIOD on the next clk (wrap-around).

Timeout:
- timeout_event = (counter==0) & ~zero_d1, where zero_d1 is counter==0 registered.
- timeout_event sets TO.

Pre-timeout:
- pre_event = RUN & PRETHR!=0 & counter=={0,PRETHR} & ~pre_d1, where pre_d1 is that compare registered.
- pre_event sets PTO.

Start/stop:
- START sets RUN.
- STOP clears RUN only when ALLOW_STOP=1.
- START and STOP in the same write: START wins.

Interrupt:
- irq = (TO & ITO) | (PTO & PIE), combinational from registers.

Reset request:
- timeout_event loads a RST_PULSE-cycle down-counter.
- resetrequest is high while that counter is nonzero.
- It asserts the cycle after timeout_event and stays high exactly RST_PULSE cycles.
- A retrigger while active reloads the pulse counter.

Simultaneous events:
- STATUS write in the same cycle as timeout_event or pre_event: the set wins, so the flag stays 1.
- Kick in the same cycle the counter reaches 0: the timeout still fires; the reload then proceeds.
- Snapshot write in the same cycle as a decrement: captures the pre-decrement value.

Reset mid-operation:
- Asynchronous reset returns every register to its reset value immediately, including an in-progress resetrequest pulse.

Decomposition:
- Package wdt_pkg holds:
  - register address constants (ADDR_STATUS..ADDR_SNAPH, ADDR_PRETHR);
  - STATUS bit indices (TO=0, RUN=1, PTO=2);
  - CONTROL bit indices (ITO=0, PIE=1, START=2, STOP=3).
- Sub-module wdt_reset_stretcher: inputs trigger; parameter RST_PULSE; output pulse.

Test Plan:
1. Defaults: COUNT_W=24, DEFAULT_PERIOD=100, RST_PULSE=3. Write CONTROL=0x0005 -> RUN=1. TO=1 exactly 101 cycles after the write. irq=1. resetrequest high for exactly 3 cycles.
2. Kick: period 100, running. Write PERIODL=50 at counter=10 -> counter=50 two cycles after the write. No TO within 50 cycles of the reload.
3. Pre-timeout: PRETHR=20, CONTROL=0x0006 (PIE and START set), period 100 -> PTO=1 and irq=1 when counter reaches 20; TO=0. Write STATUS -> irq=0.
4. Stop lock: ALLOW_STOP=0, running. Write CONTROL=0x0008 -> RUN stays 1. With ALLOW_STOP=1 the same write -> RUN=0 and the counter holds its value.
5. Snapshot/width: COUNT_W=20, PERIODH=0xFFFF, PERIODL=0x0000. Read PERIODH -> 0x000F. Write SNAPL at counter 0xF0000 -> SNAPL=0x0000, SNAPH=0x000F (read counter value 1 cycle later).
6. Collision: write STATUS in the cycle counter hits 0 -> TO reads 1. Assert reset_n=0 mid resetrequest pulse -> resetrequest=0 and readdata=0 immediately.
